// File: rtl/snn_ctrl_pkg.sv
// ============================================================================
// Module   : snn_ctrl_pkg
// Purpose  : Command codes, FSM states and command-bus entry type shared
//            by the SNN run controller and its configuration table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package snn_ctrl_pkg;

    localparam int PKG_INT_WIDTH   = 4;
    localparam int PKG_FLOAT_WIDTH = 2 * PKG_INT_WIDTH;
    localparam int PKG_ADDR_WIDTH  = 3;
    localparam int PKG_CMD_WIDTH   = 3;

    localparam logic [2:0] CMD_RUN                       = 3'd0;
    localparam logic [2:0] CMD_SET_INPUT_TRAIN_FREQUENCY = 3'd3;
    localparam logic [2:0] CMD_SET_INPUT_TRAIN_LENGTH    = 3'd4;
    localparam logic [2:0] CMD_CLEAR                     = 3'd5;
    localparam logic [2:0] CMD_IDLE                      = 3'd7;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CONFIG = 3'd1,
        CLEAR  = 3'd2,
        RUN    = 3'd3,
        DONE   = 3'd4
    } state_t;

    // One command-bus beat; addr occupies the MSBs of the packed entry.
    typedef struct packed {
        logic [PKG_ADDR_WIDTH-1:0]  addr;
        logic [PKG_CMD_WIDTH-1:0]   cmd;
        logic [PKG_FLOAT_WIDTH-1:0] cmd_arg;
    } snn_cmd_t;

endpackage

`default_nettype wire

// File: rtl/snn_cfg_table.sv
// ============================================================================
// Module   : snn_cfg_table
// Purpose  : Configuration register file, one write port and one
//            combinational read port; contents are deliberately not reset.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_cfg_table
    import snn_ctrl_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = $bits(snn_cmd_t),
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               we_i,
    input  logic [AW-1:0]      waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [AW-1:0]      raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/snn_run_controller.sv
// ============================================================================
// Module   : snn_run_controller
// Purpose  : Replays the configuration table onto the network command bus,
//            clears, runs with latched operands and captures the decision.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module snn_run_controller
    import snn_ctrl_pkg::*;
#(
    parameter int INT_WIDTH      = 4,
    parameter int ADDR_WIDTH     = 3,
    parameter int CMD_WIDTH      = 3,
    parameter int CFG_DEPTH      = 16,
    parameter int MAX_RUN_CYCLES = 40,
    localparam int FLOAT_WIDTH   = 2 * INT_WIDTH,
    localparam int IDX_W         = $clog2(CFG_DEPTH),
    localparam int CNT_W         = IDX_W + 1,
    localparam int ENTRY_W       = ADDR_WIDTH + CMD_WIDTH + FLOAT_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   cfg_we,
    input  logic [IDX_W-1:0]       cfg_waddr,
    input  logic [ENTRY_W-1:0]     cfg_wdata,
    input  logic [CNT_W-1:0]       cfg_count,
    input  logic                   start,
    input  logic [1:0]             start_in,
    input  logic                   net_out_valid,
    input  logic                   net_out,
    output logic [ADDR_WIDTH-1:0]  net_addr,
    output logic [CMD_WIDTH-1:0]   net_cmd,
    output logic [FLOAT_WIDTH-1:0] net_cmd_arg,
    output logic [1:0]             net_in,
    output logic                   busy,
    output logic                   done,
    output logic                   result,
    output logic                   timeout
);

    localparam int RUN_W = $clog2(MAX_RUN_CYCLES + 1);

    state_t                 state_q;
    logic [CNT_W-1:0]       idx_q;
    logic [CNT_W-1:0]       count_q;
    logic [CNT_W-1:0]       count_d;
    logic [RUN_W-1:0]       run_cnt_q;
    logic [RUN_W-1:0]       run_cnt_d;
    logic [1:0]             in_bits_q;
    logic [ADDR_WIDTH-1:0]  net_addr_q;
    logic [CMD_WIDTH-1:0]   net_cmd_q;
    logic [FLOAT_WIDTH-1:0] net_arg_q;
    logic [1:0]             net_in_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   result_q;
    logic                   timeout_q;

    logic                   tbl_we;
    logic [ENTRY_W-1:0]     tbl_rdata;

    // Writes only land while idle so a replay always sees a stable table.
    assign tbl_we = cfg_we && (state_q == IDLE);

    snn_cfg_table #(
        .DEPTH   (CFG_DEPTH),
        .ENTRY_W (ENTRY_W)
    ) u_cfg_table (
        .clk     (clk),
        .we_i    (tbl_we),
        .waddr_i (cfg_waddr),
        .wdata_i (cfg_wdata),
        .raddr_i (idx_q[IDX_W-1:0]),
        .rdata_o (tbl_rdata)
    );

    always_comb begin
        count_d   = (cfg_count > CNT_W'(CFG_DEPTH)) ? CNT_W'(CFG_DEPTH) : cfg_count;
        run_cnt_d = run_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            count_q    <= '0;
            run_cnt_q  <= '0;
            in_bits_q  <= '0;
            net_addr_q <= '0;
            net_cmd_q  <= CMD_WIDTH'(CMD_IDLE);
            net_arg_q  <= '0;
            net_in_q   <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        in_bits_q <= start_in;
                        count_q   <= count_d;
                        result_q  <= 1'b0;
                        timeout_q <= 1'b0;
                        busy_q    <= 1'b1;
                        if (count_d == '0) begin
                            state_q    <= CLEAR;
                            net_addr_q <= '0;
                            net_cmd_q  <= CMD_WIDTH'(CMD_CLEAR);
                            net_arg_q  <= '0;
                        end else begin
                            // idx_q rests at 0 in IDLE, so entry 0 is already on the read port.
                            state_q    <= CONFIG;
                            net_addr_q <= tbl_rdata[ENTRY_W-1 -: ADDR_WIDTH];
                            net_cmd_q  <= tbl_rdata[FLOAT_WIDTH +: CMD_WIDTH];
                            net_arg_q  <= tbl_rdata[FLOAT_WIDTH-1:0];
                            idx_q      <= CNT_W'(1);
                        end
                    end
                end
                CONFIG: begin
                    if (idx_q == count_q) begin
                        state_q    <= CLEAR;
                        idx_q      <= '0;
                        net_addr_q <= '0;
                        net_cmd_q  <= CMD_WIDTH'(CMD_CLEAR);
                        net_arg_q  <= '0;
                    end else begin
                        net_addr_q <= tbl_rdata[ENTRY_W-1 -: ADDR_WIDTH];
                        net_cmd_q  <= tbl_rdata[FLOAT_WIDTH +: CMD_WIDTH];
                        net_arg_q  <= tbl_rdata[FLOAT_WIDTH-1:0];
                        idx_q      <= idx_q + 1'b1;
                    end
                end
                CLEAR: begin
                    state_q    <= RUN;
                    run_cnt_q  <= '0;
                    net_addr_q <= '0;
                    net_cmd_q  <= CMD_WIDTH'(CMD_RUN);
                    net_arg_q  <= '0;
                    net_in_q   <= in_bits_q;
                end
                RUN: begin
                    run_cnt_q <= run_cnt_d;
                    // A decision on the final permitted cycle still counts as a decision.
                    if (net_out_valid) begin
                        state_q   <= DONE;
                        result_q  <= net_out;
                        timeout_q <= 1'b0;
                        done_q    <= 1'b1;
                        net_cmd_q <= CMD_WIDTH'(CMD_IDLE);
                        net_in_q  <= '0;
                    end else if (run_cnt_d == RUN_W'(MAX_RUN_CYCLES)) begin
                        state_q   <= DONE;
                        result_q  <= 1'b0;
                        timeout_q <= 1'b1;
                        done_q    <= 1'b1;
                        net_cmd_q <= CMD_WIDTH'(CMD_IDLE);
                        net_in_q  <= '0;
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    done_q    <= 1'b0;
                    busy_q    <= 1'b0;
                    run_cnt_q <= '0;
                end
                default: begin
                    state_q   <= IDLE;
                    net_cmd_q <= CMD_WIDTH'(CMD_IDLE);
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                end
            endcase
        end
    end

    assign net_addr    = net_addr_q;
    assign net_cmd     = net_cmd_q;
    assign net_cmd_arg = net_arg_q;
    assign net_in      = net_in_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign result      = result_q;
    assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_snn_run_controller.sv
// ============================================================================
// Module   : tb_snn_run_controller
// Purpose  : Directed self-checking bench for snn_run_controller.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_snn_run_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        cfg_we;
    logic [3:0]  cfg_waddr;
    logic [13:0] cfg_wdata;
    logic [4:0]  cfg_count;
    logic        start;
    logic [1:0]  start_in;
    logic        net_out_valid;
    logic        net_out;
    logic [2:0]  net_addr;
    logic [2:0]  net_cmd;
    logic [7:0]  net_cmd_arg;
    logic [1:0]  net_in;
    logic        busy;
    logic        done;
    logic        result;
    logic        timeout;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [13:0] E0   = {3'd1, 3'd3, 8'h08};
    localparam logic [13:0] E1   = {3'd2, 3'd3, 8'h10};
    localparam logic [13:0] E2   = {3'd0, 3'd4, 8'h02};
    localparam logic [13:0] BCLR = {3'd0, 3'd5, 8'h00};
    localparam logic [13:0] BRUN = {3'd0, 3'd0, 8'h00};

    snn_run_controller dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_we        (cfg_we),
        .cfg_waddr     (cfg_waddr),
        .cfg_wdata     (cfg_wdata),
        .cfg_count     (cfg_count),
        .start         (start),
        .start_in      (start_in),
        .net_out_valid (net_out_valid),
        .net_out       (net_out),
        .net_addr      (net_addr),
        .net_cmd       (net_cmd),
        .net_cmd_arg   (net_cmd_arg),
        .net_in        (net_in),
        .busy          (busy),
        .done          (done),
        .result        (result),
        .timeout       (timeout)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic write_entry(input logic [3:0] idx, input logic [13:0] data);
        cfg_waddr = idx;
        cfg_wdata = data;
        cfg_we    = 1'b1;
        tick();
        cfg_we    = 1'b0;
    endtask

    // Returns in cycle T+1, where edge T sampled start.
    task automatic issue_start(input logic [1:0] bits, input logic [4:0] cnt);
        start_in  = bits;
        cfg_count = cnt;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    task automatic pulse_valid(input logic v);
        net_out_valid = 1'b1;
        net_out       = v;
        tick();
        net_out_valid = 1'b0;
        net_out       = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if ({busy, done, result, timeout, net_cmd, net_addr, net_cmd_arg, net_in}
                    !== {4'b0000, 3'd7, 3'd0, 8'd0, 2'd0}) begin
                n_fail++;
                $display("FAIL reset_idle cyc%0d: got b%0b d%0b r%0b t%0b cmd%0d addr%0d arg%h in%b expected 0 0 0 0 cmd7 addr0 arg00 in00",
                         i, busy, done, result, timeout, net_cmd, net_addr, net_cmd_arg, net_in);
            end
            tick();
        end
    endtask

    task automatic test_replay();
        logic [13:0] exp_bus [5];
        exp_bus[0] = E0; exp_bus[1] = E1; exp_bus[2] = E2; exp_bus[3] = BCLR; exp_bus[4] = BRUN;
        write_entry(4'd0, E0);
        write_entry(4'd1, E1);
        write_entry(4'd2, E2);
        issue_start(2'b10, 5'd3);
        for (int k = 0; k < 5; k++) begin
            n_tests++;
            if ({net_addr, net_cmd, net_cmd_arg} !== exp_bus[k] || busy !== 1'b1) begin
                n_fail++;
                $display("FAIL replay T+%0d: got bus %h busy %b expected bus %h busy 1",
                         k + 1, {net_addr, net_cmd, net_cmd_arg}, busy, exp_bus[k]);
            end
            if (k < 4) tick();
        end
        n_tests++;
        if (net_in !== 2'b10) begin
            n_fail++;
            $display("FAIL replay_net_in: got %b expected 10", net_in);
        end
        pulse_valid(1'b0);
        n_tests++;
        if ({done, result, timeout, net_cmd, net_in} !== {3'b100, 3'd7, 2'b00}) begin
            n_fail++;
            $display("FAIL replay_fast_done: got d%b r%b t%b cmd%0d in%b expected d1 r0 t0 cmd7 in00",
                     done, result, timeout, net_cmd, net_in);
        end
        tick();
        n_tests++;
        if ({done, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL replay_idle: got done %b busy %b expected 0 0", done, busy);
        end
    endtask

    task automatic test_decision();
        issue_start(2'b01, 5'd3);
        // Valid outside RUN must be ignored.
        net_out_valid = 1'b1;
        net_out       = 1'b1;
        repeat (3) tick();
        net_out_valid = 1'b0;
        net_out       = 1'b0;
        for (int r = 1; r <= 7; r++) begin
            tick();
            n_tests++;
            if ({net_cmd, net_in, done, busy} !== {3'd0, 2'b01, 1'b0, 1'b1}) begin
                n_fail++;
                $display("FAIL decision_run%0d: got cmd%0d in%b done%b busy%b expected cmd0 in01 done0 busy1",
                         r, net_cmd, net_in, done, busy);
            end
            if (r == 7) begin
                net_out_valid = 1'b1;
                net_out       = 1'b1;
            end
        end
        tick();
        net_out_valid = 1'b0;
        net_out       = 1'b0;
        n_tests++;
        if ({done, result, timeout} !== 3'b110) begin
            n_fail++;
            $display("FAIL decision_done: got d%b r%b t%b expected d1 r1 t0", done, result, timeout);
        end
        tick();
        n_tests++;
        if ({done, busy, result} !== 3'b001) begin
            n_fail++;
            $display("FAIL decision_hold: got d%b b%b r%b expected d0 b0 r1", done, busy, result);
        end
        tick();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL decision_single_pulse: got done %b expected 0", done);
        end
    endtask

    task automatic test_timeout();
        issue_start(2'b11, 5'd0);
        n_tests++;
        if ({net_cmd, result, timeout} !== {3'd5, 2'b00}) begin
            n_fail++;
            $display("FAIL timeout_clear_at_T1: got cmd%0d r%b t%b expected cmd5 r0 t0", net_cmd, result, timeout);
        end
        for (int r = 1; r <= 40; r++) begin
            tick();
            n_tests++;
            if ({net_cmd, done, busy} !== {3'd0, 2'b01}) begin
                n_fail++;
                $display("FAIL timeout_run%0d: got cmd%0d done%b busy%b expected cmd0 done0 busy1",
                         r, net_cmd, done, busy);
            end
        end
        tick();
        n_tests++;
        if ({done, result, timeout, net_cmd} !== {3'b101, 3'd7}) begin
            n_fail++;
            $display("FAIL timeout_done: got d%b r%b t%b cmd%0d expected d1 r0 t1 cmd7",
                     done, result, timeout, net_cmd);
        end
        tick();
        n_tests++;
        if ({done, busy, timeout} !== 3'b001) begin
            n_fail++;
            $display("FAIL timeout_hold: got d%b b%b t%b expected d0 b0 t1", done, busy, timeout);
        end
    endtask

    task automatic test_same_cycle();
        issue_start(2'b00, 5'd0);
        n_tests++;
        if (timeout !== 1'b0) begin
            n_fail++;
            $display("FAIL same_cycle_cleared: got timeout %b expected 0", timeout);
        end
        for (int r = 1; r <= 40; r++) begin
            tick();
            if (r == 40) begin
                net_out_valid = 1'b1;
                net_out       = 1'b1;
            end
        end
        tick();
        net_out_valid = 1'b0;
        net_out       = 1'b0;
        n_tests++;
        if ({done, result, timeout} !== 3'b110) begin
            n_fail++;
            $display("FAIL same_cycle_valid_wins: got d%b r%b t%b expected d1 r1 t0", done, result, timeout);
        end
        tick();
    endtask

    task automatic test_ignored();
        issue_start(2'b11, 5'd3);
        repeat (4) tick();
        start     = 1'b1;
        start_in  = 2'b00;
        cfg_count = 5'd0;
        cfg_we    = 1'b1;
        cfg_waddr = 4'd0;
        cfg_wdata = 14'h3FFF;
        tick();
        start     = 1'b0;
        cfg_we    = 1'b0;
        n_tests++;
        if ({net_cmd, net_in, busy} !== {3'd0, 2'b11, 1'b1}) begin
            n_fail++;
            $display("FAIL ignored_start: got cmd%0d in%b busy%b expected cmd0 in11 busy1", net_cmd, net_in, busy);
        end
        pulse_valid(1'b0);
        n_tests++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_done: got %b expected 1", done);
        end
        tick();
        issue_start(2'b10, 5'd3);
        n_tests++;
        if ({net_addr, net_cmd, net_cmd_arg} !== E0) begin
            n_fail++;
            $display("FAIL ignored_table_e0: got %h expected %h", {net_addr, net_cmd, net_cmd_arg}, E0);
        end
        repeat (4) tick();
        pulse_valid(1'b1);
        tick();
    endtask

    task automatic test_reset_mid();
        issue_start(2'b01, 5'd3);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_tests++;
        if ({busy, done, net_cmd, net_addr, net_cmd_arg} !== {2'b00, 3'd7, 3'd0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_mid: got b%b d%b cmd%0d addr%0d arg%h expected b0 d0 cmd7 addr0 arg00",
                     busy, done, net_cmd, net_addr, net_cmd_arg);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if ({done, busy, net_cmd} !== {2'b00, 3'd7}) begin
                n_fail++;
                $display("FAIL reset_mid_idle%0d: got d%b b%b cmd%0d expected d0 b0 cmd7", i, done, busy, net_cmd);
            end
        end
        issue_start(2'b01, 5'd3);
        n_tests++;
        if ({net_addr, net_cmd, net_cmd_arg} !== E0) begin
            n_fail++;
            $display("FAIL reset_mid_e0: got %h expected %h", {net_addr, net_cmd, net_cmd_arg}, E0);
        end
        tick();
        n_tests++;
        if ({net_addr, net_cmd, net_cmd_arg} !== E1) begin
            n_fail++;
            $display("FAIL reset_mid_e1: got %h expected %h", {net_addr, net_cmd, net_cmd_arg}, E1);
        end
        repeat (3) tick();
        pulse_valid(1'b0);
        tick();
    endtask

    task automatic test_clamp();
        for (int i = 3; i < 16; i++) begin
            write_entry(4'(i), {3'(i % 8), 3'd3, 8'(i)});
        end
        issue_start(2'b00, 5'd20);
        repeat (15) tick();
        n_tests++;
        if ({net_addr, net_cmd, net_cmd_arg} !== {3'd7, 3'd3, 8'h0F}) begin
            n_fail++;
            $display("FAIL clamp_e15: got %h expected %h", {net_addr, net_cmd, net_cmd_arg}, {3'd7, 3'd3, 8'h0F});
        end
        tick();
        n_tests++;
        if ({net_addr, net_cmd, net_cmd_arg} !== BCLR) begin
            n_fail++;
            $display("FAIL clamp_clear: got %h expected %h", {net_addr, net_cmd, net_cmd_arg}, BCLR);
        end
        tick();
        n_tests++;
        if (net_cmd !== 3'd0) begin
            n_fail++;
            $display("FAIL clamp_run: got cmd %0d expected 0", net_cmd);
        end
        pulse_valid(1'b1);
        tick();
    endtask

    initial begin
        rst           = 1'b1;
        cfg_we        = 1'b0;
        cfg_waddr     = '0;
        cfg_wdata     = '0;
        cfg_count     = '0;
        start         = 1'b0;
        start_in      = '0;
        net_out_valid = 1'b0;
        net_out       = 1'b0;
        tick();
        test_reset();
        test_replay();
        test_decision();
        test_timeout();
        test_same_cycle();
        test_ignored();
        test_reset_mid();
        test_clamp();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
